// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration controller.
package fll_cfg_pkg;

    typedef enum logic [2:0] {
        WAIT_ACK_LOW,
        BOOT_REQ,
        LOCK_WAIT,
        IDLE,
        HOST_XFER
    } state_t;

    // FLL configuration register map
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CFG1   = 2'd1;
    localparam logic [1:0] REG_CFG2   = 2'd2;
    localparam logic [1:0] REG_INTEG  = 2'd3;

    // Bits needed for a counter that must be able to hold max_val
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fll_cfg_ctrl_lock_filter.sv
// Debounces the raw FLL lock: lock rises after LOCK_STABLE consecutive high
// samples and falls after LOSS_FILTER consecutive low samples.
module fll_lock_filter
    import fll_cfg_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 16,
    parameter int unsigned LOSS_FILTER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic fll_lock_i,
    output logic lock_o
);

    localparam int unsigned HI_W = cnt_width(LOCK_STABLE);
    localparam int unsigned LO_W = cnt_width(LOSS_FILTER);
    localparam logic [HI_W-1:0] HI_MAX  = HI_W'(LOCK_STABLE);
    localparam logic [HI_W-1:0] HI_LAST = HI_W'(LOCK_STABLE - 1);
    localparam logic [LO_W-1:0] LO_MAX  = LO_W'(LOSS_FILTER);
    localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOSS_FILTER - 1);

    logic [HI_W-1:0] hi_cnt;
    logic [LO_W-1:0] lo_cnt;

    // Saturating run-length counters; lock_o changes on the sample that completes a run
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt <= '0;
            lo_cnt <= '0;
            lock_o <= 1'b0;
        end else if (fll_lock_i) begin
            lo_cnt <= '0;
            if (hi_cnt != HI_MAX) hi_cnt <= hi_cnt + 1'b1;
            if (hi_cnt >= HI_LAST) lock_o <= 1'b1;
        end else begin
            hi_cnt <= '0;
            if (lo_cnt != LO_MAX) lo_cnt <= lo_cnt + 1'b1;
            if (lo_cnt >= LO_LAST) lock_o <= 1'b0;
        end
    end

endmodule

// File: rtl/fll_cfg_ctrl.sv
// FLL configuration controller: boots the FLL, switches the core clock to the
// FLL once lock is stable, forwards host accesses and handles lock loss.
module fll_cfg_ctrl
    import fll_cfg_pkg::*;
#(
    parameter logic [31:0] BOOT_CFG1    = 32'h0004_05F5,
    parameter logic [31:0] BOOT_CFG2    = 32'h0000_0104,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOSS_FILTER  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_req_i,
    input  logic        host_wrn_i,
    input  logic [1:0]  host_add_i,
    input  logic [31:0] host_wdata_i,
    output logic        host_ack_o,
    output logic [31:0] host_rdata_o,
    output logic        fll_req_o,
    output logic        fll_wrn_o,
    output logic [1:0]  fll_add_o,
    output logic [31:0] fll_wdata_o,
    input  logic        fll_ack_i,
    input  logic [31:0] fll_rdata_i,
    input  logic        fll_lock_i,
    output logic        clk_sel_o,
    output logic        lock_o,
    output logic        boot_done_o,
    output logic        lock_err_o,
    output logic        lock_lost_o
);

    localparam int unsigned WAIT_W = cnt_width(LOCK_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LOCK_TIMEOUT - 1);

    state_t            state, state_d;
    state_t            ret_state, ret_d;
    logic [1:0]        boot_idx, idx_d;
    logic [WAIT_W-1:0] wait_cnt, wait_d;
    logic              loss_pend, loss_d;

    logic        req_d, wrn_d, hack_d, sel_d, done_d, err_d, lost_d;
    logic [1:0]  add_d;
    logic [31:0] wdata_d, hrdata_d;

    logic lock_loss;
    logic host_cfg_write;
    logic fll_cfg_write;

    fll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE),
        .LOSS_FILTER (LOSS_FILTER)
    ) u_lock_filter (
        .clk        (clk),
        .rst        (rst),
        .fll_lock_i (fll_lock_i),
        .lock_o     (lock_o)
    );

    // clk_sel_o is only ever set while lock_o is high, so this level is a falling event
    assign lock_loss      = clk_sel_o && !lock_o && (state == IDLE || state == HOST_XFER);
    assign host_cfg_write = !host_wrn_i && (host_add_i == REG_CFG1 || host_add_i == REG_CFG2);
    assign fll_cfg_write  = !fll_wrn_o && (fll_add_o == REG_CFG1 || fll_add_o == REG_CFG2);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state;
        ret_d    = ret_state;
        idx_d    = boot_idx;
        wait_d   = '0;
        loss_d   = loss_pend;
        req_d    = fll_req_o;
        wrn_d    = fll_wrn_o;
        add_d    = fll_add_o;
        wdata_d  = fll_wdata_o;
        hack_d   = 1'b0;
        hrdata_d = host_rdata_o;
        sel_d    = clk_sel_o;
        done_d   = boot_done_o;
        err_d    = lock_err_o;
        lost_d   = 1'b0;

        if (lock_loss) begin
            sel_d  = 1'b0;
            lost_d = 1'b1;
            err_d  = 1'b1;
            loss_d = 1'b1;
        end

        case (state)
            WAIT_ACK_LOW: begin
                if (!fll_ack_i) state_d = ret_state;
            end

            BOOT_REQ: begin
                if (!fll_req_o) begin
                    req_d   = 1'b1;
                    wrn_d   = 1'b0;
                    add_d   = boot_idx;
                    wdata_d = (boot_idx == REG_CFG1) ? BOOT_CFG1 : BOOT_CFG2;
                end else if (fll_ack_i) begin
                    req_d   = 1'b0;
                    state_d = WAIT_ACK_LOW;
                    if (boot_idx == REG_CFG2) begin
                        ret_d = LOCK_WAIT;
                    end else begin
                        ret_d = BOOT_REQ;
                        idx_d = boot_idx + 2'd1;
                    end
                end
            end

            LOCK_WAIT: begin
                sel_d = 1'b0;
                if (lock_o) begin
                    sel_d   = 1'b1;
                    done_d  = 1'b1;
                    loss_d  = 1'b0;
                    state_d = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    loss_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_cnt + 1'b1;
                end
            end

            IDLE: begin
                if (lock_loss) begin
                    state_d = LOCK_WAIT;
                end else if (host_req_i && boot_done_o) begin
                    state_d = HOST_XFER;
                    wrn_d   = host_wrn_i;
                    add_d   = host_add_i;
                    wdata_d = host_wdata_i;
                    if (host_cfg_write) sel_d = 1'b0;
                end
            end

            HOST_XFER: begin
                if (!fll_req_o) begin
                    req_d = 1'b1;
                end else if (fll_ack_i) begin
                    req_d    = 1'b0;
                    hack_d   = 1'b1;
                    hrdata_d = fll_rdata_i;
                    state_d  = WAIT_ACK_LOW;
                    ret_d    = (loss_pend || lock_loss || fll_cfg_write) ? LOCK_WAIT : IDLE;
                end
            end

            default: state_d = WAIT_ACK_LOW;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= WAIT_ACK_LOW;
            ret_state    <= BOOT_REQ;
            boot_idx     <= REG_CFG1;
            wait_cnt     <= '0;
            loss_pend    <= 1'b0;
            fll_req_o    <= 1'b0;
            fll_wrn_o    <= 1'b0;
            fll_add_o    <= '0;
            fll_wdata_o  <= '0;
            host_ack_o   <= 1'b0;
            host_rdata_o <= '0;
            clk_sel_o    <= 1'b0;
            boot_done_o  <= 1'b0;
            lock_err_o   <= 1'b0;
            lock_lost_o  <= 1'b0;
        end else begin
            state        <= state_d;
            ret_state    <= ret_d;
            boot_idx     <= idx_d;
            wait_cnt     <= wait_d;
            loss_pend    <= loss_d;
            fll_req_o    <= req_d;
            fll_wrn_o    <= wrn_d;
            fll_add_o    <= add_d;
            fll_wdata_o  <= wdata_d;
            host_ack_o   <= hack_d;
            host_rdata_o <= hrdata_d;
            clk_sel_o    <= sel_d;
            boot_done_o  <= done_d;
            lock_err_o   <= err_d;
            lock_lost_o  <= lost_d;
        end
    end

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Self-checking bench for fll_cfg_ctrl with an FLL responder model and scoreboards.
module tb_fll_cfg_ctrl;
    import fll_cfg_pkg::*;

    localparam logic [31:0] CFG1 = 32'h0004_05F5;
    localparam logic [31:0] CFG2 = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_req_i, host_wrn_i;
    logic [1:0]  host_add_i;
    logic [31:0] host_wdata_i;
    logic        host_ack_o;
    logic [31:0] host_rdata_o;
    logic        fll_req_o, fll_wrn_o;
    logic [1:0]  fll_add_o;
    logic [31:0] fll_wdata_o;
    logic        fll_ack_i;
    logic [31:0] fll_rdata_i;
    logic        fll_lock_i;
    logic        clk_sel_o, lock_o, boot_done_o, lock_err_o, lock_lost_o;

    fll_cfg_ctrl #(
        .BOOT_CFG1    (CFG1),
        .BOOT_CFG2    (CFG2),
        .LOCK_STABLE  (16),
        .LOCK_TIMEOUT (4096),
        .LOSS_FILTER  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host_req_i   (host_req_i),
        .host_wrn_i   (host_wrn_i),
        .host_add_i   (host_add_i),
        .host_wdata_i (host_wdata_i),
        .host_ack_o   (host_ack_o),
        .host_rdata_o (host_rdata_o),
        .fll_req_o    (fll_req_o),
        .fll_wrn_o    (fll_wrn_o),
        .fll_add_o    (fll_add_o),
        .fll_wdata_o  (fll_wdata_o),
        .fll_ack_i    (fll_ack_i),
        .fll_rdata_i  (fll_rdata_i),
        .fll_lock_i   (fll_lock_i),
        .clk_sel_o    (clk_sel_o),
        .lock_o       (lock_o),
        .boot_done_o  (boot_done_o),
        .lock_err_o   (lock_err_o),
        .lock_lost_o  (lock_lost_o)
    );

    initial forever #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        wrn;
        logic [1:0]  add;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        relock;
    } host_vec_t;

    xfer_t       fll_q[$];
    logic [31:0] host_q[$];
    host_vec_t   vecs[6];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fll_acks = 0, boot_base = 0, last_ack_cyc = 0;
    int unsigned n_host_ack = 0, early_ack = 0, n_lost = 0;
    int unsigned mcnt = 0;
    logic        model_en = 1'b0;
    logic        force_ack = 1'b0;
    logic [31:0] model_rdata = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // FLL responder: acks 3 sampled cycles after req, drops ack once req drops
    initial begin
        fll_ack_i   = 1'b0;
        fll_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!model_en) begin
                mcnt      = 0;
                fll_ack_i = force_ack;
            end else if (fll_ack_i) begin
                if (!fll_req_o) fll_ack_i = 1'b0;
            end else if (fll_req_o) begin
                mcnt++;
                if (mcnt >= 3) begin
                    xfer_t exp_x;
                    mcnt         = 0;
                    fll_ack_i    = 1'b1;
                    fll_rdata_i  = model_rdata;
                    n_fll_acks++;
                    last_ack_cyc = cyc + 1;
                    check("fll_xfer_expected", 64'(fll_q.size() != 0), 64'd1);
                    if (fll_q.size() != 0) begin
                        exp_x = fll_q.pop_front();
                        check("fll_xfer", {fll_wrn_o, fll_add_o, fll_wdata_o}, exp_x);
                    end
                end
            end
        end
    end

    // Host-side monitor: host ack scoreboard and pulse counters
    initial forever begin
        @(posedge clk);
        #1;
        if (host_ack_o) begin
            n_host_ack++;
            if (!boot_done_o) early_ack++;
            check("host_ack_expected", 64'(host_q.size() != 0), 64'd1);
            if (host_q.size() != 0) check("host_rdata", host_rdata_o, host_q.pop_front());
        end
        if (lock_lost_o) n_lost++;
    end

    task automatic push_boot();
        fll_q.push_back(xfer_t'{1'b0, REG_CFG1, CFG1});
        fll_q.push_back(xfer_t'{1'b0, REG_CFG2, CFG2});
    endtask

    task automatic start_reset();
        rst        = 1'b1;
        model_en   = 1'b0;
        force_ack  = 1'b0;
        fll_lock_i = 1'b0;
        fll_q.delete();
        host_q.delete();
        tick(5);
    endtask

    task automatic end_reset();
        push_boot();
        boot_base = n_fll_acks;
        model_en  = 1'b1;
        rst       = 1'b0;
    endtask

    // Two boot writes, lock 50 cycles later, clk_sel exactly 16 cycles after first high sample
    task automatic boot_check(input string tag);
        int unsigned l_cyc;
        for (int i = 0; i < 200 && n_fll_acks < boot_base + 2; i++) tick();
        check({tag, "_boot_writes"}, n_fll_acks - boot_base, 2);
        tick(50);
        check({tag, "_prelock"}, {clk_sel_o, boot_done_o}, 2'b00);
        fll_lock_i = 1'b1;
        l_cyc = cyc + 1;
        for (int i = 0; i < 100 && !clk_sel_o; i++) tick();
        check({tag, "_sel_delay"}, cyc - l_cyc, 16);
        check({tag, "_done_err"}, {boot_done_o, lock_err_o, lock_o}, 3'b101);
    endtask

    task automatic host_op(input string tag, input logic wrn, input logic [1:0] add,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input logic exp_sel_req, input logic relock);
        logic seen_req, got_ack;
        int unsigned ack_base;
        fll_q.push_back(xfer_t'{wrn, add, wdata});
        host_q.push_back(rdata);
        model_rdata  = rdata;
        ack_base     = n_host_ack;
        host_wrn_i   = wrn;
        host_add_i   = add;
        host_wdata_i = wdata;
        host_req_i   = 1'b1;
        seen_req = 1'b0;
        got_ack  = 1'b0;
        for (int i = 0; i < 200 && !got_ack; i++) begin
            tick();
            if (fll_req_o && !seen_req) begin
                seen_req = 1'b1;
                check({tag, "_sel_at_req"}, clk_sel_o, exp_sel_req);
            end
            if (host_ack_o) got_ack = 1'b1;
        end
        host_req_i = 1'b0;
        check({tag, "_ack"}, got_ack, 1'b1);
        if (relock) begin
            for (int i = 0; i < 50 && !clk_sel_o; i++) tick();
            check({tag, "_relock"}, clk_sel_o, 1'b1);
        end else begin
            tick(3);
            check({tag, "_sel_after"}, clk_sel_o, exp_sel_req);
        end
        tick(3);
        check({tag, "_ack_count"}, n_host_ack - ack_base, 1);
    endtask

    initial begin
        int unsigned l_cyc, lost_base, ack_base, viol;
        logic saw_low, got_ack;

        rst = 1'b1;
        host_req_i = 1'b0; host_wrn_i = 1'b0; host_add_i = '0; host_wdata_i = '0;
        fll_lock_i = 1'b0;

        vecs[0] = '{1'b1, REG_STATUS, 32'h0,         32'h0000_0011, 1'b0};
        vecs[1] = '{1'b0, REG_INTEG,  32'h0000_1234, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b0, REG_CFG1,   32'h0004_0800, 32'h0000_0000, 1'b1};
        vecs[3] = '{1'b1, REG_CFG2,   32'h0,         32'h0000_0104, 1'b0};
        vecs[4] = '{1'b0, REG_CFG2,   32'h0000_0204, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, REG_INTEG,  32'h0,         32'hDEAD_BEEF, 1'b0};

        // Scenario 1: reset state and boot
        start_reset();
        check("reset_fll", {fll_req_o, fll_wrn_o, fll_add_o, fll_wdata_o}, 36'h0);
        check("reset_misc", {host_ack_o, host_rdata_o, clk_sel_o, lock_o, boot_done_o,
                             lock_err_o, lock_lost_o}, 38'h0);
        end_reset();
        boot_check("s1");

        // Scenario 3 and general host traffic
        for (int i = 0; i < 6; i++)
            host_op($sformatf("vec%0d", i), vecs[i].wrn, vecs[i].add, vecs[i].wdata,
                    vecs[i].rdata, !vecs[i].relock, vecs[i].relock);

        // Scenario 4: 3-cycle glitch is filtered, 4-cycle loss is declared
        lost_base  = n_lost;
        fll_lock_i = 1'b0;
        tick(3);
        fll_lock_i = 1'b1;
        tick(10);
        check("s4_glitch", {n_lost - lost_base, 32'(clk_sel_o), 32'(lock_err_o)}, {32'd0, 32'd1, 32'd0});
        fll_lock_i = 1'b0;
        tick(4);
        fll_lock_i = 1'b1;
        l_cyc   = cyc + 1;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!clk_sel_o) saw_low = 1'b1;
            if (clk_sel_o && saw_low) break;
        end
        check("s4_sel_dropped", saw_low, 1'b1);
        check("s4_relock_delay", cyc - l_cyc, 16);
        tick(2);
        check("s4_lost_pulses", n_lost - lost_base, 1);
        check("s4_err", lock_err_o, 1'b1);

        // Scenario 6: host request held across boot
        start_reset();
        host_req_i   = 1'b1;
        host_wrn_i   = 1'b1;
        host_add_i   = REG_INTEG;
        host_wdata_i = '0;
        model_rdata  = 32'h0000_0606;
        early_ack    = 0;
        ack_base     = n_host_ack;
        end_reset();
        fll_q.push_back(xfer_t'{1'b1, REG_INTEG, 32'h0});
        host_q.push_back(32'h0000_0606);
        boot_check("s6");
        got_ack = 1'b0;
        for (int i = 0; i < 50 && !got_ack; i++) begin
            tick();
            if (host_ack_o) got_ack = 1'b1;
        end
        host_req_i = 1'b0;
        tick(20);
        check("s6_ack_count", n_host_ack - ack_base, 1);
        check("s6_early_ack", early_ack, 0);

        // Scenario 2: lock never rises, timeout after 4096 LOCK_WAIT cycles
        start_reset();
        end_reset();
        for (int i = 0; i < 200 && n_fll_acks < boot_base + 2; i++) tick();
        check("s2_boot_writes", n_fll_acks - boot_base, 2);
        for (int i = 0; i < 5000 && !lock_err_o; i++) tick();
        check("s2_timeout_cycle", cyc - last_ack_cyc, 4097);
        check("s2_state", {clk_sel_o, boot_done_o, lock_err_o}, 3'b011);
        host_op("s2_read", 1'b1, REG_STATUS, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);

        // Scenario 5: reset mid-request with a late ack held for 10 cycles
        start_reset();
        rst = 1'b0;
        for (int i = 0; i < 20 && !fll_req_o; i++) tick();
        check("s5_req_pending", fll_req_o, 1'b1);
        rst = 1'b1;
        tick(2);
        force_ack = 1'b1;
        tick(3);
        push_boot();
        boot_base = n_fll_acks;
        rst  = 1'b0;
        viol = 0;
        repeat (7) begin
            tick();
            if (fll_req_o) viol++;
        end
        force_ack = 1'b0;
        model_en  = 1'b1;
        check("s5_no_req_while_ack", viol, 0);
        boot_check("s5");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
